m_stack_seq: RTL and testbench

Stack-machine sequencer that sits directly upstream of the `m_stack` LIFO in the MPU datapath. It accepts one stack instruction at a time over a valid/ready handshake and expands it into single-cycle push/pop strobes on the stack port. It also performs ADD/SUB/AND, DUP and SWAP on the popped operands and reports the new top-of-stack or an error. It keeps its own depth counter, so under- and overflow are rejected before any stack access is made.

---
 rtl/m_stack_seq_if.sv | 34 +++
 rtl/m_stack_seq.sv | 182 ++++++++++++++++++
 tb/tb_m_stack_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_stack_seq_if.sv
// Instruction, result and stack-port bundle for the m_stack_seq sequencer.
// The slave modport is the sequencer; the master modport is whatever drives
// instructions and models the downstream stack.
interface m_stack_seq_if #(
  parameter int WORD = 16,
  parameter int PAGE = 1024
);
  localparam int DW = $clog2(PAGE + 1);

  logic            op_valid;
  logic            op_ready;
  logic [2:0]      op_code;
  logic [WORD-1:0] op_imm;
  logic            res_valid;
  logic [WORD-1:0] res_data;
  logic            res_err;
  logic [DW-1:0]   depth;
  logic            stk_push;
  logic            stk_pop;
  logic [WORD:0]   stk_wdata;
  logic [WORD:0]   stk_rdata;

  modport master (
    output op_valid, op_code, op_imm, stk_rdata,
    input  op_ready, res_valid, res_data, res_err, depth,
           stk_push, stk_pop, stk_wdata
  );

  modport slave (
    input  op_valid, op_code, op_imm, stk_rdata,
    output op_ready, res_valid, res_data, res_err, depth,
           stk_push, stk_pop, stk_wdata
  );
endinterface

// File: rtl/m_stack_seq.sv
// Stack-machine sequencer: expands one stack instruction at a time into
// single-cycle push/pop strobes for the downstream LIFO, performs the ALU,
// DUP and SWAP operations on popped operands, and tracks stack depth so that
// under/overflow is rejected before the stack is touched.
module m_stack_seq #(
  parameter int WORD = 16,
  parameter int PAGE = 1024
) (
  input logic         clk,
  input logic         reset,
  m_stack_seq_if.slave bus
);
  localparam int            DW   = $clog2(PAGE + 1);
  localparam logic [DW-1:0] FULL = DW'(PAGE);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_DUP, OP_SWAP
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_POP_A, S_CAP_A, S_POP_B, S_CAP_B, S_PUSH_1, S_PUSH_2, S_DONE
  } state_e;

  state_e          state, state_nx;
  op_e             op_in, op;
  logic [WORD-1:0] imm, a, b;
  logic            err;
  logic [DW-1:0]   depth;
  logic            accept, reject;
  logic            op_ready, stk_push, stk_pop, res_valid;
  logic [WORD-1:0] alu_val, push_val, res_val;

  // Bit WORD of the stack read data carries nothing for this block.
  logic unused_rdata_msb;
  assign unused_rdata_msb = bus.stk_rdata[WORD];

  assign op_in  = op_e'(bus.op_code);
  assign accept = (state == S_IDLE) && bus.op_valid;

  // Depth-based admission check for the instruction being offered.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    reject = 1'b0;
    case (op_in)
      OP_PUSH:                          reject = (depth >= FULL);
      OP_POP:                           reject = (depth < ONE);
      OP_DUP:                           reject = (depth < ONE) || (depth >= FULL);
      OP_ADD, OP_SUB, OP_AND, OP_SWAP:  reject = (depth < TWO);
      default:                          reject = 1'b0;
    endcase
  end

  // FSM state register; reset aborts any instruction in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_nx  = state;
    op_ready  = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          if (reject || op_in == OP_NOP) state_nx = S_DONE;
          else if (op_in == OP_PUSH)     state_nx = S_PUSH_1;
          else                           state_nx = S_POP_A;
        end
      end
      S_POP_A: begin
        stk_pop  = 1'b1;
        state_nx = S_CAP_A;
      end
      S_CAP_A: begin
        if (op == OP_POP)      state_nx = S_DONE;
        else if (op == OP_DUP) state_nx = S_PUSH_1;
        else                   state_nx = S_POP_B;
      end
      S_POP_B: begin
        stk_pop  = 1'b1;
        state_nx = S_CAP_B;
      end
      S_CAP_B: state_nx = S_PUSH_1;
      S_PUSH_1: begin
        stk_push = 1'b1;
        state_nx = (op == OP_DUP || op == OP_SWAP) ? S_PUSH_2 : S_DONE;
      end
      S_PUSH_2: begin
        stk_push = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Instruction latch, error flag and operand capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op  <= OP_NOP;
      imm <= '0;
      err <= 1'b0;
      a   <= '0;
      b   <= '0;
    end else begin
      if (accept) begin
        op  <= op_in;
        imm <= bus.op_imm;
        err <= reject;
      end
      if (state == S_CAP_A) a <= bus.stk_rdata[WORD-1:0];
      if (state == S_CAP_B) b <= bus.stk_rdata[WORD-1:0];
    end
  end

  // Depth counter follows the strobes; the two are never high together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        depth <= '0;
    else if (stk_push) depth <= depth + ONE;
    else if (stk_pop)  depth <= depth - ONE;
  end

  // Value to push and value to report, selected by the latched instruction.
  always_comb begin
    alu_val  = '0;
    push_val = '0;
    res_val  = '0;
    case (op)
      OP_ADD:  alu_val = b + a;
      OP_SUB:  alu_val = b - a;
      OP_AND:  alu_val = b & a;
      default: alu_val = '0;
    endcase
    case (op)
      OP_PUSH: begin
        push_val = imm;
        res_val  = imm;
      end
      OP_POP:  res_val = a;
      OP_ADD, OP_SUB, OP_AND: begin
        push_val = alu_val;
        res_val  = alu_val;
      end
      OP_DUP: begin
        push_val = a;
        res_val  = a;
      end
      OP_SWAP: begin
        // Old top goes down first, so the old second word becomes the top.
        push_val = (state == S_PUSH_2) ? b : a;
        res_val  = b;
      end
      default: begin
        push_val = '0;
        res_val  = '0;
      end
    endcase
    if (err) res_val = '0;
  end

  assign bus.op_ready  = op_ready;
  assign bus.stk_push  = stk_push;
  assign bus.stk_pop   = stk_pop;
  assign bus.stk_wdata = stk_push ? {1'b0, push_val} : '0;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_valid ? res_val : '0;
  assign bus.res_err   = res_valid & err;
  assign bus.depth     = depth;
endmodule

// File: tb/tb_m_stack_seq.sv
// Self-checking bench for m_stack_seq: a behavioural stack device on the
// stack port, an instruction-level reference model built on a queue, and
// directed plus random instruction streams.
module tb_m_stack_seq;
  localparam int WORD = 16;
  localparam int PAGE = 1024;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [WORD-1:0] ref_q[$];
  logic [WORD:0]   mem [0:PAGE-1];
  int              sp;

  m_stack_seq_if #(.WORD(WORD), .PAGE(PAGE)) bus ();

  m_stack_seq #(.WORD(WORD), .PAGE(PAGE)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream LIFO: read data appears the cycle after a pop; bit WORD of
  // the read data is forced high to show that the sequencer ignores it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp            <= 0;
      bus.stk_rdata <= '0;
    end else if (bus.stk_push && sp < PAGE) begin
      mem[sp] <= bus.stk_wdata;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_rdata <= {1'b1, mem[sp-1][WORD-1:0]};
      sp            <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check it against the reference model.
  task automatic run_op(input logic [2:0] code, input logic [WORD-1:0] imm,
                        output logic [WORD-1:0] got);
    int n, exp_lat, exp_push, exp_pop, pushes, pops, lat, w;
    bit exp_err, seen, ready_bad, msb_bad;
    logic [WORD-1:0] a, b, exp_res;
    logic got_err;
    logic [10:0] got_depth;

    n = ref_q.size();
    case (code)
      3'd1:                 exp_err = (n >= PAGE);
      3'd2:                 exp_err = (n < 1);
      3'd3, 3'd4, 3'd5, 3'd7: exp_err = (n < 2);
      3'd6:                 exp_err = (n < 1) || (n >= PAGE);
      default:              exp_err = 1'b0;
    endcase
    exp_res = '0; exp_push = 0; exp_pop = 0; exp_lat = 1;
    if (!exp_err) begin
      case (code)
        3'd1: begin
          ref_q.push_back(imm);
          exp_res = imm; exp_push = 1; exp_lat = 2;
        end
        3'd2: begin
          a = ref_q.pop_back();
          exp_res = a; exp_pop = 1; exp_lat = 3;
        end
        3'd3, 3'd4, 3'd5: begin
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          if (code == 3'd3)      exp_res = b + a;
          else if (code == 3'd4) exp_res = b - a;
          else                   exp_res = b & a;
          ref_q.push_back(exp_res);
          exp_push = 1; exp_pop = 2; exp_lat = 6;
        end
        3'd6: begin
          a = ref_q[ref_q.size()-1];
          ref_q.push_back(a);
          exp_res = a; exp_push = 2; exp_pop = 1; exp_lat = 5;
        end
        3'd7: begin
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          ref_q.push_back(a);
          ref_q.push_back(b);
          exp_res = b; exp_push = 2; exp_pop = 2; exp_lat = 7;
        end
        default: ;
      endcase
    end

    @(negedge clk);
    w = 0;
    while (!bus.op_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_imm   = imm;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;

    seen = 0; lat = 0; pushes = 0; pops = 0; ready_bad = 0; msb_bad = 0;
    got = '0; got_err = 1'b0; got_depth = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.stk_push) begin
        pushes++;
        if (bus.stk_wdata[WORD]) msb_bad = 1;
      end
      if (bus.stk_pop) pops++;
      if (bus.op_ready) ready_bad = 1;
      if (bus.res_valid) begin
        seen = 1; lat = c;
        got = bus.res_data; got_err = bus.res_err; got_depth = bus.depth;
        break;
      end
    end
    check("latency", seen ? lat : 0, exp_lat);
    check("res_err", got_err, exp_err);
    check("res_data", got, exp_res);
    check("depth", got_depth, ref_q.size());
    check("push_count", pushes, exp_push);
    check("pop_count", pops, exp_pop);
    check("ready_low_busy", ready_bad, 0);
    check("wdata_msb", msb_bad, 0);
    @(negedge clk);
    check("ready_after_done", bus.op_ready, 1);
    check("single_res_pulse", bus.res_valid, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_q.delete();
  endtask

  initial begin
    logic [WORD-1:0] got;
    logic [WORD-1:0] vals [4];
    int acc, pushes, last_acc, res_idx;
    bit gap_bad, ready_bad, res_seen;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_imm = '0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_depth", bus.depth, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_strobes", {bus.stk_push, bus.stk_pop}, 0);
    check("rst_wdata", bus.stk_wdata, 0);
    rst_n = 1'b1;

    // Basic PUSH and ADD.
    run_op(3'd1, 16'h0005, got); check("basic_push5", got, 16'h0005);
    run_op(3'd1, 16'h0003, got); check("basic_push3", got, 16'h0003);
    run_op(3'd3, 16'h0000, got); check("basic_add", got, 16'h0008);

    // SUB wrap and AND mask.
    run_op(3'd1, 16'h0001, got);
    run_op(3'd1, 16'h0002, got);
    run_op(3'd4, 16'h0000, got); check("sub_wrap", got, 16'hFFFF);
    run_op(3'd1, 16'h00F0, got);
    run_op(3'd5, 16'h0000, got); check("and_mask", got, 16'h00F0);

    // DUP then SWAP, then pop the results back.
    run_op(3'd1, 16'h1234, got);
    run_op(3'd1, 16'h5678, got);
    run_op(3'd6, 16'h0000, got); check("dup", got, 16'h5678);
    run_op(3'd7, 16'h0000, got); check("swap", got, 16'h5678);
    run_op(3'd2, 16'h0000, got); check("pop1", got, 16'h5678);
    run_op(3'd2, 16'h0000, got); check("pop2", got, 16'h5678);
    run_op(3'd2, 16'h0000, got); check("pop3", got, 16'h1234);

    // Underflow rejection: drain, POP at empty, ADD with one entry, NOP.
    while (ref_q.size() > 0) run_op(3'd2, 16'h0000, got);
    run_op(3'd2, 16'h0000, got);
    check("empty_depth", bus.depth, 0);
    run_op(3'd1, 16'h0042, got);
    run_op(3'd3, 16'h0000, got);
    run_op(3'd0, 16'h0000, got);
    run_op(3'd2, 16'h0000, got); check("pop_after_reject", got, 16'h0042);

    // Handshake: op_valid held high with four queued PUSHes.
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    @(negedge clk);
    acc = 0; pushes = 0; last_acc = 0; res_idx = 0; gap_bad = 0; ready_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.stk_push) begin
        pushes++;
        if (bus.op_ready) ready_bad = 1;
      end
      if (bus.res_valid) begin
        if (bus.op_ready) ready_bad = 1;
        if (res_idx < 4) check("hs_res_data", bus.res_data, vals[res_idx]);
        res_idx++;
      end
      if (bus.op_ready) begin
        if (acc == 4) break;
        if (acc > 0 && c - last_acc != 3) gap_bad = 1;
        last_acc = c;
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd1;
        bus.op_imm   = vals[acc];
        ref_q.push_back(vals[acc]);
        acc++;
      end
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    check("hs_accepts", acc, 4);
    check("hs_push_pulses", pushes, 4);
    check("hs_results", res_idx, 4);
    check("hs_spacing", gap_bad, 0);
    check("hs_ready_low", ready_bad, 0);
    check("hs_depth", bus.depth, 4);

    // Reset during CAP_B of a SWAP (depth 4 -> 2 pops -> 2 at CAP_B).
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd7;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("swap_pop_b", bus.stk_pop, 1);
    @(negedge clk);
    check("cap_b_depth", bus.depth, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_strobes", {bus.stk_push, bus.stk_pop}, 0);
    check("rst_async_depth", bus.depth, 0);
    check("rst_async_ready", bus.op_ready, 1);
    res_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid) res_seen = 1;
    end
    rst_n = 1'b1;
    ref_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid || bus.stk_push || bus.stk_pop) res_seen = 1;
    end
    check("rst_no_activity", res_seen, 0);
    check("post_rst_depth", bus.depth, 0);
    check("post_rst_ready", bus.op_ready, 1);
    run_op(3'd1, 16'hAAAA, got); check("post_rst_push", got, 16'hAAAA);

    // Fill to capacity, then overflow attempts.
    while (ref_q.size() < PAGE) run_op(3'd1, WORD'($urandom), got);
    check("full_depth", bus.depth, PAGE);
    run_op(3'd1, 16'hBEEF, got);
    check("overflow_depth", bus.depth, PAGE);
    run_op(3'd6, 16'h0000, got);
    run_op(3'd7, 16'h0000, got);
    run_op(3'd2, 16'h0000, got);
    run_op(3'd6, 16'h0000, got);

    // Random instruction stream from a clean stack.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      run_op(3'($urandom_range(0, 7)), WORD'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
